// File: rtl/ghost_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ghost_motion_ctrl
//
// Per-frame motion sequencer for the ghost sprite. On every startOfFrame
// pulse it advances a small FSM (IDLE / PATROL / STUNNED) and updates the
// sprite top-left position and facing direction. The ghost patrols between
// X_MIN and X_MAX, reversing at each wall. After a collision it freezes for
// STUN_FRAMES frames, then resumes in the opposite direction.
//
// Ports
//   clk           in   pixel clock
//   resetN        in   asynchronous, active-low reset
//   startOfFrame  in   one-cycle pulse per video frame
//   enable        in   game running; only looked at on startOfFrame
//   collision     in   ghost/player overlap, any cycle, any length
//   topLeft_x     out  sprite top-left x (registered)
//   topLeft_y     out  sprite top-left y (constant INIT_Y)
//   x_direction   out  0 = moving right, 1 = moving left (mirrored bitmap)
//   stunned       out  high while the ghost is frozen after a collision
// ---------------------------------------------------------------------------
module ghost_motion_ctrl #(
    parameter int unsigned INIT_X      = 100,
    parameter int unsigned INIT_Y      = 200,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 608,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned STUN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        collision,
    output logic [31:0] topLeft_x,
    output logic [31:0] topLeft_y,
    output logic        x_direction,
    output logic        stunned
);

    localparam int unsigned CNT_W = (STUN_FRAMES > 1) ? $clog2(STUN_FRAMES) : 1;

    localparam logic [31:0]      INIT_X_W   = 32'(INIT_X);
    localparam logic [31:0]      INIT_Y_W   = 32'(INIT_Y);
    localparam logic [31:0]      X_MIN_W    = 32'(X_MIN);
    localparam logic [31:0]      X_MAX_W    = 32'(X_MAX);
    localparam logic [31:0]      SPEED_W    = 32'(SPEED);
    localparam logic [CNT_W-1:0] STUN_LAST  = CNT_W'(STUN_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PATROL  = 2'd1,
        ST_STUNNED = 2'd2
    } state_e;

    state_e           state_q,      state_d;
    logic [31:0]      x_q,          x_d;
    logic             dir_q,        dir_d;
    logic             stunned_q,    stunned_d;
    logic [CNT_W-1:0] stun_cnt_q,   stun_cnt_d;
    logic             coll_latch_q, coll_latch_d;

    // A collision seen in the SOF cycle itself still counts for this frame.
    logic hit;
    assign hit = coll_latch_q | collision;

    always_comb begin
        // NOTE: every signal gets a hold default before any branch, so no
        // path through the block can leave one unassigned and infer a latch.
        state_d      = state_q;
        x_d          = x_q;
        dir_d        = dir_q;
        stunned_d    = stunned_q;
        stun_cnt_d   = stun_cnt_q;
        coll_latch_d = coll_latch_q | collision;

        if (startOfFrame) begin
            // The latch is consumed by every frame, whatever the state.
            coll_latch_d = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Entering PATROL does not move the sprite this frame.
                    if (enable) state_d = ST_PATROL;
                end

                ST_PATROL: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (hit) begin
                        // Collision beats a wall flip on the same frame.
                        state_d    = ST_STUNNED;
                        stun_cnt_d = STUN_LAST;
                        stunned_d  = 1'b1;
                    end else if (!dir_q) begin
                        if (x_q + SPEED_W >= X_MAX_W) begin
                            x_d   = X_MAX_W;
                            dir_d = 1'b1;
                        end else begin
                            x_d = x_q + SPEED_W;
                        end
                    end else begin
                        // Compare before subtracting so x never wraps below X_MIN.
                        if (x_q <= X_MIN_W + SPEED_W) begin
                            x_d   = X_MIN_W;
                            dir_d = 1'b0;
                        end else begin
                            x_d = x_q - SPEED_W;
                        end
                    end
                end

                ST_STUNNED: begin
                    if (!enable) begin
                        state_d    = ST_IDLE;
                        stunned_d  = 1'b0;
                        stun_cnt_d = '0;
                    end else if (stun_cnt_q == '0) begin
                        state_d   = ST_PATROL;
                        dir_d     = ~dir_q;
                        stunned_d = 1'b0;
                    end else begin
                        stun_cnt_d = stun_cnt_q - 1'b1;
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    stunned_d = 1'b0;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            x_q          <= INIT_X_W;
            dir_q        <= 1'b0;
            stunned_q    <= 1'b0;
            stun_cnt_q   <= '0;
            coll_latch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            dir_q        <= dir_d;
            stunned_q    <= stunned_d;
            stun_cnt_q   <= stun_cnt_d;
            coll_latch_q <= coll_latch_d;
        end
    end

    assign topLeft_x   = x_q;
    assign topLeft_y   = INIT_Y_W;   // the ghost never moves vertically
    assign x_direction = dir_q;
    assign stunned     = stunned_q;

endmodule
